// File: rtl/mult_sequencer_pkg.sv
// mult_sequencer_pkg
// Shared constants for the shift-add multiplier: step codes seen by the
// multiplier control decoder, the default operand width, and the phase type
// that the top level decodes from the step code.
package mult_sequencer_pkg;

    localparam int unsigned MUL_WIDTH_DEFAULT = 8;

    localparam logic [3:0] MUL_STEP_LOAD = 4'd0;
    localparam logic [3:0] MUL_STEP_DONE = 4'(MUL_WIDTH_DEFAULT + 1);

    typedef enum logic [1:0] {
        PhIdle,
        PhCalc,
        PhDone,
        PhIllegal
    } mul_phase_e;

    // Done code for an arbitrary operand width (WIDTH+1).
    function automatic logic [3:0] mul_step_done(input int unsigned width);
        return 4'(width + 1);
    endfunction

endpackage

// File: rtl/mult_sequencer_if.sv
// mult_sequencer_if
// Handshake/operand bundle between the ALU operation selector (master) and
// the multiplier sequencer (slave).
//   start    master->slave  operation request
//   a, b     master->slave  multiplicand / multiplier
//   contagem slave->master  current step code
//   busy     slave->master  operation in progress (calc or done)
//   done     slave->master  one-cycle result-valid pulse
//   produto  slave->master  2*WIDTH-bit product
interface mult_sequencer_if #(
    parameter int unsigned WIDTH = 8
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [3:0]           contagem;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   produto;

    modport master (
        output start, a, b,
        input  contagem, busy, done, produto
    );

    modport slave (
        input  start, a, b,
        output contagem, busy, done, produto
    );
endinterface

// File: rtl/mult_step_counter.sv
// mult_step_counter
// 4-bit step counter with asynchronous reset and synchronous clear.
//   clk      system clock, rising edge
//   reset    asynchronous active-high reset
//   inc      advance the count by one
//   clr      synchronous clear to 0 (takes priority over inc)
//   contagem current step code
module mult_step_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] contagem
);
    import mult_sequencer_pkg::*;

    logic [3:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= MUL_STEP_LOAD;
        end else if (clr) begin
            r_count <= MUL_STEP_LOAD;
        end else if (inc) begin
            r_count <= r_count + 4'd1;
        end
    end

    assign contagem = r_count;
endmodule

// File: rtl/mult_sequencer.sv
// mult_sequencer
// Sequential shift-add unsigned multiplier. One operand bit is consumed per
// clock; a full operation takes WIDTH+2 cycles (load, WIDTH calc, done).
//   clk    system clock, rising edge
//   reset  asynchronous active-high reset
//   bus    slave side of mult_sequencer_if (start/a/b in,
//          contagem/busy/done/produto out)
module mult_sequencer #(
    parameter int unsigned WIDTH = mult_sequencer_pkg::MUL_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    mult_sequencer_if.slave  bus
);
    import mult_sequencer_pkg::*;

    localparam logic [3:0] STEP_DONE = mul_step_done(WIDTH);
    localparam logic [3:0] STEP_LAST = 4'(WIDTH);

    logic [3:0]         w_count;
    mul_phase_e         w_phase;
    logic               w_inc;
    logic               w_clr;
    logic               w_load;

    logic [WIDTH-1:0]   r_m;
    // {carry, hi, lo}: lo starts as the multiplier and drains out the bottom
    // while the product fills in from the top.
    logic [2*WIDTH:0]   r_acc;

    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH:0]   w_pre_shift;

    mult_step_counter u_counter (
        .clk      (clk),
        .reset    (reset),
        .inc      (w_inc),
        .clr      (w_clr),
        .contagem (w_count)
    );

    // Phase decode and counter control.
    always_comb begin
        w_phase = PhIllegal;
        w_inc   = 1'b0;
        w_clr   = 1'b0;
        w_load  = 1'b0;

        if (w_count == MUL_STEP_LOAD) begin
            w_phase = PhIdle;
        end else if (w_count <= STEP_LAST) begin
            w_phase = PhCalc;
        end else if (w_count == STEP_DONE) begin
            w_phase = PhDone;
        end

        unique case (w_phase)
            PhIdle: begin
                w_load = bus.start;
                w_inc  = bus.start;
            end
            PhCalc:    w_inc = 1'b1;
            PhDone:    w_clr = 1'b1;
            PhIllegal: w_clr = 1'b1;
            default:   w_clr = 1'b1;
        endcase
    end

    // Conditional add of the multiplicand into the high half, then the
    // whole accumulator shifts right in the same edge.
    always_comb begin
        w_sum       = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_m};
        w_pre_shift = r_acc;
        if (r_acc[0]) begin
            w_pre_shift = {w_sum, r_acc[WIDTH-1:0]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_m   <= '0;
            r_acc <= '0;
        end else if (w_load) begin
            r_m   <= bus.a;
            r_acc <= {1'b0, {WIDTH{1'b0}}, bus.b};
        end else if (w_phase == PhCalc) begin
            r_acc <= {1'b0, w_pre_shift[2*WIDTH:1]};
        end
    end

    assign bus.contagem = w_count;
    assign bus.busy     = (w_phase == PhCalc) || (w_phase == PhDone);
    assign bus.done     = (w_phase == PhDone);
    assign bus.produto  = r_acc[2*WIDTH-1:0];
endmodule
